// File: rtl/shared_bus_arbiter.sv
// shared_bus_arbiter: round-robin N-master arbiter driving one shared slave port with wait states and back-pressure.
// Define ARB_TIMEOUT_EN to force an error acknowledge when the slave stalls for TIMEOUT_CYCLES.
module shared_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int WAIT_STATES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_req,
  input  logic [NUM_MASTERS-1:0]              m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]       m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]       m_wdata,
  input  logic [(NUM_MASTERS*DATA_W/8)-1:0]   m_be,
  output logic [NUM_MASTERS-1:0]              m_grant,
  output logic [NUM_MASTERS-1:0]              m_ack,
  output logic [NUM_MASTERS-1:0]              m_err,
  output logic [DATA_W-1:0]                   m_rdata,
  output logic                                s_en,
  output logic                                s_we,
  output logic [ADDR_W-1:0]                   s_addr,
  output logic [DATA_W-1:0]                   s_wdata,
  output logic [DATA_W/8-1:0]                 s_be,
  input  logic [DATA_W-1:0]                   s_rdata,
  input  logic                                s_ready
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int BW = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
  state_t                 state_q, state_d;
  logic [IW-1:0]          own_q, own_d, last_q, last_d, win;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, ack_q, ack_d, err_q, err_d, mask_q, mask_d, elig;
  logic [3:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [BW-1:0]          be_q, be_d;
  logic                   we_q, we_d, en_q, en_d, done, tout;
  logic [ADDR_W-1:0]      addr_a  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_a [NUM_MASTERS];
  logic [BW-1:0]          be_a    [NUM_MASTERS];
  int                     idx, wi;
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
    assign be_a[g]    = m_be[g*BW +: BW];
  end
  assign done = state_q == ACCESS && cnt_q == 4'd0 && s_ready;
`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  assign tout   = state_q == ACCESS && !done && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign tcnt_d = state_q == ACCESS ? tcnt_q + 1'b1 : '0;
  always_ff @(posedge clk) tcnt_q <= rst ? '0 : tcnt_d;
`else
  assign tout = 1'b0;
`endif
  // Scan downward so the candidate nearest to last+1 is the final assignment and wins.
  always_comb begin
    elig = m_req & ~mask_q;
    idx  = 0;
    wi   = 0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_MASTERS;
      if (elig[IW'(idx)]) wi = idx;
    end
    win = IW'(wi);
  end
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    en_d    = en_q;
    ack_d   = (done || tout) ? grant_q : '0;
    err_d   = tout ? grant_q : '0;
    mask_d  = state_q == ACK ? grant_q : '0;
    case (state_q)
      IDLE: if (|elig) begin
        state_d = ACCESS;
        own_d   = win;
        grant_d = NUM_MASTERS'(1) << win;
        we_d    = m_we[win];
        addr_d  = addr_a[win];
        wdata_d = wdata_a[win];
        be_d    = be_a[win];
        cnt_d   = 4'(WAIT_STATES);
        en_d    = 1'b1;
      end
      ACCESS: begin
        cnt_d = cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
        if (done || tout) begin
          state_d = ACK;
          last_d  = own_q;
          en_d    = 1'b0;
          rdata_d = tout ? '1 : s_rdata;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      en_q    <= en_d;
    end
  assign m_grant = grant_q;
  assign m_ack   = ack_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign s_en    = en_q;
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_be    = be_q;
endmodule
